// File: rtl/lcd_write_sequencer.sv
// ============================================================================
// Module  : lcd_write_sequencer
// Brief   : Turns single-cycle processor writes into timed HD44780-style
//           LCD bus cycles (setup, E pulse, hold, execution wait).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_write_sequencer #(
  parameter int T_SETUP     = 2,
  parameter int T_EN_HIGH   = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 1000,
  parameter int T_EXEC_LONG = 41000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_strobe,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       clr_overrun,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data
);

  // Each phase loads (length - 1) and leaves when the counter reaches zero.
  localparam logic [15:0] c_setup_ld = 16'(T_SETUP - 1);
  localparam logic [15:0] c_en_ld    = 16'(T_EN_HIGH - 1);
  localparam logic [15:0] c_hold_ld  = 16'(T_HOLD - 1);
  localparam logic [15:0] c_exec_ld  = 16'(T_EXEC - 1);
  localparam logic [15:0] c_long_ld  = 16'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_cnt_zero;
  logic        w_done_nxt;
  logic        w_accept;
  logic        w_drop;
  logic        w_long_cmd;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;
  logic        r_lcd_e;
  logic        r_lcd_rs;
  logic [7:0]  r_lcd_data;

  assign w_cnt_zero = (r_cnt == 16'd0);
  assign w_accept   = (r_state == S_IDLE) && wr_strobe;
  assign w_drop     = (r_state != S_IDLE) && wr_strobe;
  // Clear display / return home need the long execution time.
  assign w_long_cmd = !r_lcd_rs && ((r_lcd_data == 8'h01) || (r_lcd_data == 8'h02) ||
                                    (r_lcd_data == 8'h03));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_strobe) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = c_setup_ld;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_ENABLE;
          w_cnt_nxt   = c_en_ld;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_ENABLE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_hold_ld;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_long_cmd ? c_long_ld : c_exec_ld;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Bus-facing outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_lcd_e    <= 1'b0;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_lcd_e <= (w_state_nxt == S_ENABLE);
      if (w_accept) begin
        r_lcd_rs   <= wr_rs;
        r_lcd_data <= wr_data;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overrun  = r_overrun;
  assign lcd_e    = r_lcd_e;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_data = r_lcd_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
// ============================================================================
// Module  : tb_lcd_write_sequencer
// Brief   : Directed self-checking bench for lcd_write_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_write_sequencer;

  localparam int c_setup = 2;
  localparam int c_en    = 3;
  localparam int c_hold  = 2;
  localparam int c_exec  = 5;
  localparam int c_long  = 20;
  localparam int c_short_busy = c_setup + c_en + c_hold + c_exec;
  localparam int c_long_busy  = c_setup + c_en + c_hold + c_long;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_strobe = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_overrun = 1'b0;
  logic       busy, done, overrun, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int  n_tests = 0;
  int  n_fail  = 0;
  logic exp_ov = 1'b0;

  lcd_write_sequencer #(
    .T_SETUP    (c_setup),
    .T_EN_HIGH  (c_en),
    .T_HOLD     (c_hold),
    .T_EXEC     (c_exec),
    .T_EXEC_LONG(c_long)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_strobe  (wr_strobe),
    .wr_rs      (wr_rs),
    .wr_data    (wr_data),
    .clr_overrun(clr_overrun),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},  16'(busy),  16'd0);
    chk({tag, " done"},  16'(done),  16'd0);
    chk({tag, " lcd_e"}, 16'(lcd_e), 16'd0);
  endtask

  // Strobe issued now (cycle 0); checks every cycle through the done cycle.
  // drop_at/clr_at (>0) inject a strobe / clr_overrun during that cycle.
  task automatic xfer(input string tag, input logic rs, input logic [7:0] data,
                      input int nbusy, input int drop_at, input int clr_at);
    wr_strobe = 1'b1;
    wr_rs     = rs;
    wr_data   = data;
    step();
    wr_strobe = 1'b0;
    wr_rs     = ~rs;
    wr_data   = 8'hFF;
    for (int c = 1; c <= nbusy + 1; c++) begin
      chk($sformatf("%s c%0d busy", tag, c), 16'(busy), 16'(c <= nbusy));
      chk($sformatf("%s c%0d lcd_e", tag, c), 16'(lcd_e),
          16'((c > c_setup) && (c <= c_setup + c_en)));
      chk($sformatf("%s c%0d done", tag, c), 16'(done), 16'(c == nbusy + 1));
      chk($sformatf("%s c%0d rs", tag, c), 16'(lcd_rs), 16'(rs));
      chk($sformatf("%s c%0d data", tag, c), 16'(lcd_data), 16'(data));
      chk($sformatf("%s c%0d rw", tag, c), 16'(lcd_rw), 16'd0);
      chk($sformatf("%s c%0d overrun", tag, c), 16'(overrun), 16'(exp_ov));
      if (c <= nbusy) begin
        if (c == drop_at) begin
          wr_strobe = 1'b1;
          wr_rs     = ~rs;
          wr_data   = 8'hAA;
        end
        if (c == clr_at) clr_overrun = 1'b1;
        step();
        if (c == drop_at) exp_ov = 1'b1;
        else if (c == clr_at) exp_ov = 1'b0;
        wr_strobe   = 1'b0;
        clr_overrun = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk_idle("reset");
    chk("reset overrun", 16'(overrun), 16'd0);
    chk("reset rs", 16'(lcd_rs), 16'd0);
    chk("reset rw", 16'(lcd_rw), 16'd0);
    chk("reset data", 16'(lcd_data), 16'h00);
    reset = 1'b0;
    step();
    chk_idle("post-reset");

    // Ignored wr_rs/wr_data without strobe
    wr_rs = 1'b1; wr_data = 8'h99;
    step();
    chk("nostrobe data", 16'(lcd_data), 16'h00);
    chk("nostrobe busy", 16'(busy), 16'd0);
    step();

    // Data write
    xfer("data41", 1'b1, 8'h41, c_short_busy, 0, 0);
    step();
    chk_idle("after data41");

    // Clear / home / normal command execution times
    xfer("clr01", 1'b0, 8'h01, c_long_busy, 0, 0);
    step();
    xfer("home02", 1'b0, 8'h02, c_long_busy, 0, 0);
    step();
    xfer("cmd03", 1'b0, 8'h03, c_long_busy, 0, 0);
    step();
    xfer("fn38", 1'b0, 8'h38, c_short_busy, 0, 0);
    step();
    xfer("cmd04", 1'b0, 8'h04, c_short_busy, 0, 0);
    step();
    xfer("dat01", 1'b1, 8'h01, c_short_busy, 0, 0);
    step();

    // Overrun on a strobe at cycle 6, then clear
    xfer("ovr", 1'b1, 8'h41, c_short_busy, 6, 0);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    exp_ov = 1'b0;
    chk("ovr cleared", 16'(overrun), 16'd0);
    chk("ovr cleared done", 16'(done), 16'd0);

    // Drop on the last WAIT cycle still counts as overrun
    xfer("ovr_last", 1'b1, 8'h42, c_short_busy, c_short_busy, 0);
    step();

    // Clear and drop in the same cycle: drop wins, later clear works
    xfer("ovr_sim", 1'b1, 8'h55, c_short_busy, 4, 4);
    step();
    xfer("ovr_clr", 1'b1, 8'h56, c_short_busy, 0, 9);
    step();
    chk("ovr_clr final", 16'(overrun), 16'd0);

    // Back-to-back: second strobe on the done cycle is accepted
    xfer("b2b_a", 1'b1, 8'h41, c_short_busy, 0, 0);
    xfer("b2b_b", 1'b0, 8'h38, c_short_busy, 0, 0);
    step();

    // Reset during ENABLE aborts; strobe held during reset is ignored
    wr_strobe = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    step();
    wr_strobe = 1'b0;
    step(); step(); step();
    chk("rst cyc4 lcd_e", 16'(lcd_e), 16'd1);
    reset = 1'b1;
    step();
    chk_idle("rst cyc5");
    chk("rst cyc5 rs", 16'(lcd_rs), 16'd0);
    chk("rst cyc5 data", 16'(lcd_data), 16'h00);
    chk("rst cyc5 overrun", 16'(overrun), 16'd0);
    wr_strobe = 1'b1; wr_rs = 1'b1; wr_data = 8'h77;
    step();
    wr_strobe = 1'b0;
    reset = 1'b0;
    chk("rst strobe busy", 16'(busy), 16'd0);
    chk("rst strobe data", 16'(lcd_data), 16'h00);
    for (int i = 0; i < c_long_busy; i++) begin
      step();
      chk($sformatf("rst quiet %0d", i), 16'({busy, done, lcd_e}), 16'd0);
    end
    xfer("post_rst", 1'b1, 8'h5A, c_short_busy, 0, 0);
    step();
    chk_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
